// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing generator: controller states,
// default 640x480 timing and a helper that sums the four segments of an axis.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vga_state_e;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  function automatic int vga_total(input int active, input int fp,
                                   input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-enable divider: produces a one-clk tick every CLK_DIV cycles while
// run is high; the count restarts from zero whenever run drops.
module vga_pix_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be at least 1");
  end

  logic [DW-1:0] div;

  // Free-running modulo-CLK_DIV count, held at zero while not running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (!run || div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign tick = run && (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-enable strobe,
// start/drain control and registered sync/de/position/marker outputs.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame_cnt
// output that counts frame_start pulses.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          pix_tick,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          busy
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL >= (1 << CW)) begin : g_h_total_too_big
    $error("H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL >= (1 << CW)) begin : g_v_total_too_big
    $error("V_TOTAL does not fit in CW bits");
  end

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  vga_state_e    state, state_nxt;
  logic          run;
  logic          tick;
  logic          frame_end;
  logic [CW-1:0] hc, vc;
  // High on the first clk a counter position is valid (after a tick or start).
  logic          pos_new;

  assign run       = (state != IDLE);
  assign busy      = run;
  assign frame_end = (hc == H_LAST) && (vc == V_LAST);

  vga_pix_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_div (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .tick (tick)
  );

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: start on en, drain to the end of the frame when en drops.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = DRAIN;
      DRAIN: begin
        if (en) begin
          state_nxt = RUN;
        end else if (tick && frame_end) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage 0: raster position counters ----
  // Horizontal/vertical position advance once per pixel tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (state == IDLE) begin
      hc <= '0;
      vc <= '0;
    end else if (tick) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + CW'(1);
      end else begin
        hc <= hc + CW'(1);
      end
    end
  end

  // Flags the first clk of each new position, including the one at start-up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_new <= 1'b0;
    end else begin
      pos_new <= (state == IDLE) ? en : tick;
    end
  end

  // ---- stage 1: registered output decode ----
  // Sync/de/position/markers decoded from the counters, forced idle in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_tick    <= 1'b0;
      h_sync      <= ~HS_POL;
      v_sync      <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (state == IDLE) begin
      pix_tick    <= 1'b0;
      h_sync      <= ~HS_POL;
      v_sync      <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= tick;
      h_sync      <= (hc >= HS_START && hc < HS_END) ? HS_POL : ~HS_POL;
      v_sync      <= (vc >= VS_START && vc < VS_END) ? VS_POL : ~VS_POL;
      de          <= (hc < H_ACT) && (vc < V_ACT);
      x           <= hc;
      y           <= vc;
      line_start  <= pos_new && (hc == '0);
      frame_start <= pos_new && (hc == '0) && (vc == '0);
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter steps at the end of each clk in which frame_start is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= 16'd0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small raster (H 8/2/2/2, V 4/1/1/1) with a
// frame-level reference model, plus a CLK_DIV=1 instance.
module tb_vga_timing_gen;

  localparam int CW  = 11;
  localparam int D   = 2;
  localparam int HA  = 8;
  localparam int HFP = 2;
  localparam int HSY = 2;
  localparam int HBP = 2;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VSY = 1;
  localparam int VBP = 1;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int FL  = D * HT * VT;
  localparam logic [28:0] RST_V = {1'b0, 1'b1, 1'b1, 1'b0, 22'd0, 3'b000};

  logic clk;
  logic reset;
  logic en, en1;

  logic          pix_tick, h_sync, v_sync, de, line_start, frame_start, busy;
  logic [CW-1:0] x, y;
  logic          pix_tick1, h_sync1, v_sync1, de1, line_start1, frame_start1, busy1;
  logic [CW-1:0] x1, y1;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt, frame_cnt1;
`endif

  int n_chk;
  int n_err;

  vga_timing_gen #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .pix_tick(pix_tick), .h_sync(h_sync), .v_sync(v_sync), .de(de),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .busy(busy)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
  ) dut1 (
    .clk(clk), .reset(reset), .en(en1),
    .pix_tick(pix_tick1), .h_sync(h_sync1), .v_sync(v_sync1), .de(de1),
    .x(x1), .y(y1), .line_start(line_start1), .frame_start(frame_start1),
    .busy(busy1)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(frame_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [28:0] obs, obs1;
  assign obs  = {pix_tick, h_sync, v_sync, de, x, y, line_start, frame_start, busy};
  assign obs1 = {pix_tick1, h_sync1, v_sync1, de1, x1, y1, line_start1, frame_start1, busy1};

  // Reference model: the raster is a cycle index t since start; position and
  // every output follow from t by division, 1 clk behind the model state.
  int          m_st;   // 0 stopped, 1 running, 2 finishing the frame
  int          m_t;
  logic [27:0] exp_regs;
  logic [28:0] exp_v;
  assign exp_v = {exp_regs, (m_st != 0)};

  function automatic logic [27:0] model_regs(input int st, input int t);
    int p, hc, vc;
    logic tk, fst, hs, vs, d;
    if (st == 0) return RST_V[28:1];
    p   = t / D;
    hc  = p % HT;
    vc  = (p / HT) % VT;
    tk  = (t % D) == D - 1;
    fst = (t % D) == 0;
    hs  = !(hc >= HA + HFP && hc < HA + HFP + HSY);
    vs  = !(vc >= VA + VFP && vc < VA + VFP + VSY);
    d   = (hc < HA) && (vc < VA);
    return {tk, hs, vs, d, CW'(hc), CW'(vc), fst && hc == 0, fst && hc == 0 && vc == 0};
  endfunction

  function automatic int model_next_st(input int st, input int t, input logic e);
    if (st == 0) return e ? 1 : 0;
    if (e) return 1;
    if (st == 2 && t == FL - 1) return 0;
    return 2;
  endfunction

  function automatic int model_next_t(input int st, input int t, input logic e);
    if (st == 0) return 0;
    if (st == 2 && !e && t == FL - 1) return 0;
    return (t + 1) % FL;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st     <= 0;
      m_t      <= 0;
      exp_regs <= RST_V[28:1];
    end else begin
      exp_regs <= model_regs(m_st, m_t);
      m_st     <= model_next_st(m_st, m_t, en);
      m_t      <= model_next_t(m_st, m_t, en);
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (obs !== RST_V) begin
      n_err++; $display("FAIL reset_state got=%h want=%h", obs, RST_V);
    end
    n_chk++;
    if (obs1 !== RST_V) begin
      n_err++; $display("FAIL reset_state_div1 got=%h want=%h", obs1, RST_V);
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    n_chk++;
    if (frame_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt);
    end
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (obs !== RST_V) begin
      n_err++; $display("FAIL idle_after_reset got=%h want=%h", obs, RST_V);
    end
  endtask

  task automatic test_startup();
    en = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b1 || frame_start !== 1'b0) begin
      n_err++; $display("FAIL start_busy got busy=%b fs=%b want busy=1 fs=0", busy, frame_start);
    end
    @(negedge clk);
    n_chk++;
    if (frame_start !== 1'b1 || x !== '0 || y !== '0 || pix_tick !== 1'b0) begin
      n_err++;
      $display("FAIL start_frame got fs=%b x=%0d y=%0d tick=%b want fs=1 x=0 y=0 tick=0",
               frame_start, x, y, pix_tick);
    end
    @(negedge clk);
    n_chk++;
    if (pix_tick !== 1'b1) begin
      n_err++; $display("FAIL first_tick got=%b want=1", pix_tick);
    end
    n_chk++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL start_model got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_small_timing();
    int waited, hs_cnt, hs_x0, vs_cnt, vs_y0, de_cnt, extra_fs;
    waited = 0;
    while (frame_start !== 1'b1 && waited < 400) begin
      @(negedge clk); waited++;
    end
    n_chk++;
    if (waited >= 400) begin
      n_err++; $display("FAIL timing_wait_frame got=timeout want=frame_start");
    end
    hs_cnt = 0; hs_x0 = -1; vs_cnt = 0; vs_y0 = -1; de_cnt = 0; extra_fs = 0;
    for (int i = 0; i < FL; i++) begin
      if (i > 0 && frame_start === 1'b1) extra_fs++;
      if (y == 0 && h_sync === 1'b0) begin
        if (hs_x0 < 0) hs_x0 = int'(x);
        hs_cnt++;
      end
      if (v_sync === 1'b0) begin
        if (vs_y0 < 0) vs_y0 = int'(y);
        vs_cnt++;
      end
      if (y == 0 && de === 1'b1) de_cnt++;
      @(negedge clk);
      n_chk++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL timing_model cyc=%0d got=%h want=%h", i, obs, exp_v);
      end
    end
    n_chk++;
    if (hs_cnt != 4 || hs_x0 != 10) begin
      n_err++; $display("FAIL hsync_pulse got len=%0d x0=%0d want len=4 x0=10", hs_cnt, hs_x0);
    end
    n_chk++;
    if (vs_cnt != 28 || vs_y0 != 5) begin
      n_err++; $display("FAIL vsync_pulse got len=%0d y0=%0d want len=28 y0=5", vs_cnt, vs_y0);
    end
    n_chk++;
    if (de_cnt != 16) begin
      n_err++; $display("FAIL de_per_line got=%0d want=16", de_cnt);
    end
    n_chk++;
    if (frame_start !== 1'b1 || extra_fs != 0) begin
      n_err++; $display("FAIL frame_length got fs=%b extra=%0d want fs=1 extra=0", frame_start, extra_fs);
    end
  endtask

  task automatic test_drain();
    int waited;
    waited = 0;
    while (!(x == 3 && y == 2 && busy === 1'b1) && waited < 400) begin
      @(negedge clk); waited++;
    end
    n_chk++;
    if (waited >= 400) begin
      n_err++; $display("FAIL drain_wait got=timeout want=x3y2");
    end
    en = 1'b0;
    waited = 0;
    while (busy !== 1'b0 && waited < 400) begin
      @(negedge clk); waited++;
      n_chk++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL drain_model got=%h want=%h", obs, exp_v);
      end
    end
    n_chk++;
    if (busy !== 1'b0 || x != 13 || y != 6) begin
      n_err++; $display("FAIL drain_last got busy=%b x=%0d y=%0d want busy=0 x=13 y=6", busy, x, y);
    end
    @(negedge clk);
    n_chk++;
    if (de !== 1'b0 || x !== '0 || y !== '0 || busy !== 1'b0) begin
      n_err++; $display("FAIL drain_idle got de=%b x=%0d y=%0d busy=%b want 0 0 0 0", de, x, y, busy);
    end
  endtask

  task automatic test_redrain();
    int waited, idle_cyc, fs_cnt;
    en = 1'b1;
    waited = 0;
    while (!(x == 0 && y == 2 && busy === 1'b1) && waited < 400) begin
      @(negedge clk); waited++;
    end
    n_chk++;
    if (waited >= 400) begin
      n_err++; $display("FAIL redrain_wait got=timeout want=y2");
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    idle_cyc = 0; fs_cnt = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) idle_cyc++;
      if (frame_start === 1'b1) fs_cnt++;
      n_chk++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL redrain_model got=%h want=%h", obs, exp_v);
      end
    end
    n_chk++;
    if (idle_cyc != 0 || fs_cnt != 2) begin
      n_err++; $display("FAIL redrain_continuity got idle=%0d fs=%0d want idle=0 fs=2", idle_cyc, fs_cnt);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      @(negedge clk);
      n_chk++;
      if (obs !== exp_v) begin
        n_err++; bad++;
        if (bad < 10) $display("FAIL random_model cyc=%0d got=%h want=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    int waited, fs_cnt, busy_cnt;
    en = 1'b1;
    waited = 0;
    while (!(x == 5 && busy === 1'b1) && waited < 800) begin
      @(negedge clk); waited++;
    end
    n_chk++;
    if (waited >= 800) begin
      n_err++; $display("FAIL reset_mid_wait got=timeout want=x5");
    end
    en = 1'b0;
    reset = 1'b1;
    #1;
    n_chk++;
    if (obs !== RST_V) begin
      n_err++; $display("FAIL reset_mid got=%h want=%h", obs, RST_V);
    end
    @(negedge clk);
    reset = 1'b0;
    fs_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) fs_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
    n_chk++;
    if (fs_cnt != 0 || busy_cnt != 0) begin
      n_err++; $display("FAIL reset_no_drain got fs=%0d busy=%0d want 0 0", fs_cnt, busy_cnt);
    end
    en = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (frame_start !== 1'b1 || obs !== exp_v) begin
      n_err++; $display("FAIL restart_after_reset got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_div1();
    int low_cnt, fs_cnt, waited;
    en1 = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy1 !== 1'b1) begin
      n_err++; $display("FAIL div1_busy got=%b want=1", busy1);
    end
    low_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pix_tick1 !== 1'b1) low_cnt++;
    end
    n_chk++;
    if (low_cnt != 0) begin
      n_err++; $display("FAIL div1_tick got low=%0d want low=0", low_cnt);
    end
    fs_cnt = 0; waited = 0;
    while (fs_cnt < 4 && waited < 1000) begin
      if (frame_start1 === 1'b1) fs_cnt++;
      if (fs_cnt < 4) begin
        @(negedge clk); waited++;
      end
    end
    n_chk++;
    if (fs_cnt != 4) begin
      n_err++; $display("FAIL div1_frames got=%0d want=4", fs_cnt);
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    n_chk++;
    if (frame_cnt1 !== 16'd3) begin
      n_err++; $display("FAIL frame_cnt got=%0d want=3", frame_cnt1);
    end
`endif
    en1 = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    en    = 1'b0;
    en1   = 1'b0;
    reset = 1'b0;
    #2;
    test_reset();
    test_startup();
    test_small_timing();
    test_drain();
    test_redrain();
    test_random();
    test_reset_mid();
    test_div1();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for the display pipeline. It replaces the fixed 640x480 decoder with one that has configurable porch, sync and active timings, configurable sync polarity, and a single-clock pixel-enable strobe in place of a derived pixel clock. It adds clean start/stop control and registered frame and line markers. It sits between the system clock and the pixel source / RGB output stage.

## Interface
- CLK_DIV, 4: `clk` cycles per pixel; must be ≥1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: asserted level of `h_sync`.
- VS_POL, 0: asserted level of `v_sync`.
- CW, 11: width of the counters and of `x`/`y`.
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- en  in  1  request raster generation.
- pix_tick  out  1  one-`clk` pixel strobe; downstream logic advances on it.
- h_sync  out  1  horizontal sync, polarity set by HS_POL.
- v_sync  out  1  vertical sync, polarity set by VS_POL.
- de  out  1  display enable: high while the current pixel is in the visible area.
- x  out  CW  current pixel column.
- y  out  CW  current line.
- line_start  out  1  one-`clk` pulse when `x`=0 first appears.
- frame_start  out  1  one-`clk` pulse when (0,0) first appears.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Elaboration fails if H_TOTAL or V_TOTAL is ≥ 2**CW.
- Divider `div` counts 0..CLK_DIV-1 only while not IDLE. `pix_tick` = (`div`==CLK_DIV-1). With CLK_DIV=1, `pix_tick` is high on every non-IDLE cycle.
- Counters `hc`/`vc` advance on `pix_tick`:
  - `hc` wraps at H_TOTAL-1.
  - `vc` increments when `hc` wraps, and wraps at V_TOTAL-1.
- State machine (IDLE, RUN, DRAIN):
  - IDLE→RUN when `en`=1. `div`, `hc` and `vc` are 0 on entry.
  - RUN→DRAIN when `en`=0.
  - DRAIN→RUN when `en`=1; the raster continues without discontinuity.
  - DRAIN→IDLE on the `pix_tick` where `hc`=H_TOTAL-1 and `vc`=V_TOTAL-1. The counters return to 0. No partial frame is ever emitted.
- Output decode, registered from `hc`/`vc`/state:
  - `h_sync` = HS_POL when H_ACTIVE+H_FP ≤ `hc` < H_ACTIVE+H_FP+H_SYNC; otherwise !HS_POL. `v_sync` follows the same rule on `vc`.
  - `de` = (`hc`<H_ACTIVE) && (`vc`<V_ACTIVE).
  - `x`=`hc`, `y`=`vc`.
- In IDLE: `de`=0, syncs at their inactive level, `x`=`y`=0, pulses 0.
- `line_start`/`frame_start` fire on the first output cycle of a new position:
  - They pulse at each counter wrap.
  - They also pulse on the first output cycle after IDLE→RUN.

## Timing
- Reset values: `pix_tick`=0, `h_sync`=!HS_POL, `v_sync`=!VS_POL, `de`=0, `x`=`y`=0, `line_start`=`frame_start`=0, `busy`=0, state IDLE.
- Registered outputs lag the counters by exactly 1 `clk`.
- After `en` rises in IDLE:
  - `busy`=1 and the state is RUN 1 `clk` later.
  - `frame_start` pulses 1 `clk` after that, with `x`=`y`=0.
  - The first `pix_tick` occurs CLK_DIV cycles after RUN entry.
- Each position is held on the outputs for exactly CLK_DIV `clk` cycles.
- Reset asserted mid-frame: everything returns to reset values immediately (asynchronously). No drain occurs.
- `en` toggling inside one pixel period has no effect on timing. Only the state changes.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined:
  - Adds output `frame_cnt` [15:0].
  - `frame_cnt` increments in the same `clk` that `frame_start` is asserted and wraps 65535→0.
  - Reset value 0. It holds its value through IDLE.
- VGA_TIMING_FRAME_CNT_EN not defined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `vga_pkg` contains:
  - the state enum `vga_state_e` {IDLE, RUN, DRAIN};
  - localparams for the default 640x480 timing;
  - a `vga_total()` function returning active+fp+sync+bp.
- One sub-module, `vga_pix_div`: the CLK_DIV divider.
  - Inputs: `clk`, `reset`, `run`.
  - Output: `tick`.
  - `div` is cleared whenever `run`=0.

## Test plan
- Reset with defaults: all outputs at their reset values. Raise `en` → `frame_start` pulse 2 `clk` later with `x`=`y`=0. First `pix_tick` 4 `clk` after RUN entry.
- Small timing (H 8/2/2/2, V 4/1/1/1, CLK_DIV=2):
  - `h_sync` low for 4 `clk` starting at `x`=10;
  - `v_sync` low for 28 `clk` starting at `y`=5;
  - `de` high for 16 `clk` per visible line;
  - frame length 196 `clk`.
- Same small timing, drop `en` at `x`=3,`y`=2 → frame completes through `x`=13,`y`=6. Then `busy`=0, `de`=0, `x`=`y`=0.
- Drop `en`, then re-raise it while in DRAIN → no extra `frame_start` beyond the normal wrap. Counters remain continuous.
- Assert `reset` at `x`=5 mid-frame → all outputs return to reset values in the same cycle. No `frame_start` until `en` is reapplied.
- CLK_DIV=1 with VGA_TIMING_FRAME_CNT_EN defined: `pix_tick` is high on every cycle. `frame_cnt` reads 3 after the fourth `frame_start`.
